instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Reader side of the program-counter interface in the multi-cycle RV32I core. The control FSM pulses fetch_start, and this block samples the current pc and issues a read request to instruction memory over a valid/ready request channel plus a valid-only response channel. It latches the returned word into the instruction register, exposes the decoded fields (opcode, func3, register indices) that the PC, ALU and register file consume, and reports misaligned-address and response-timeout errors.

Parameters:
TIMEOUT, 16, maximum WAIT-state cycles without mem_rsp_valid before a timeout error (legal range 2..255)
NOP_INSTR, 32'h0000_0013, instruction register reset value (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_start  in  1  one-cycle request from control FSM to fetch at pc
pc  in  32  current program counter, sampled on accepted fetch_start
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request when high with mem_req_valid
mem_addr  out  32  word address of request, stable while mem_req_valid
mem_rsp_valid  in  1  response data valid (no backpressure)
mem_rsp_data  in  32  returned instruction word
instr  out  32  instruction register
instr_pc  out  32  address the current instr was fetched from
opcode  out  7  instr[6:0]
func3  out  3  instr[14:12]
rd  out  5  instr[11:7]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
fetch_busy  out  1  high in REQ and WAIT
fetch_done  out  1  one-cycle pulse on completion, success or error
fetch_error  out  1  high when last fetch failed; cleared on next accepted fetch_start
err_cause  out  2  01 misaligned, 10 timeout, 00 none; held with fetch_error

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: state IDLE, mem_req_valid 0, mem_addr 0, instr NOP_INSTR (so opcode 7'b0010011, other fields 0), instr_pc 0, fetch_busy 0, fetch_done 0, fetch_error 0, err_cause 00, timeout counter 0.
- Reset asserted mid-fetch: immediate return to reset values, with mem_req_valid dropped asynchronously. A response arriving after reset release while in IDLE is ignored.
- The decode fields are combinational slices of the instr register.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on fetch_start, clear fetch_error and err_cause.
  - If pc[1:0]==00: addr_q<=pc and go to REQ.
  - Otherwise: fetch_error<=1, err_cause<=01, go to DONE with no memory request issued and instr/instr_pc unchanged.
- REQ: mem_req_valid=1, mem_addr=addr_q, held constant until the handshake.
  - On mem_req_valid&mem_req_ready: go to WAIT and clear the counter.
  - mem_rsp_valid is ignored in REQ.
- WAIT:
  - On mem_rsp_valid: instr<=mem_rsp_data, instr_pc<=addr_q, go to DONE.
  - Otherwise: counter++. If the counter reaches TIMEOUT-1 with no response: fetch_error<=1, err_cause<=10, instr unchanged, go to DONE.
  - A response arriving in the same cycle as the timeout wins: the fetch succeeds.
- DONE: fetch_done=1 for exactly one cycle, then IDLE.
- Responses arriving in IDLE or DONE (late, after a timeout) are discarded.
- fetch_start is ignored while not in IDLE, including in DONE.
- Minimum latency: fetch_start in cycle 0 → mem_req_valid in cycle 1. With ready in cycle 1 and response in cycle 2, fetch_done and the new instr are visible in cycle 3.
- Each added cycle of ready or response delay adds one cycle of latency.
- A misaligned fetch signals fetch_done in cycle 1.
- pc changes after fetch_start is accepted have no effect on the in-flight request.

Test Plan:
- Reset → instr=0x00000013, opcode=0010011, all handshake/status outputs 0. Assert rst_n=0 while in WAIT → mem_req_valid drops immediately; a response arriving after release is ignored.
- fetch_start, pc=0x100, ready=1 immediately, rsp 0x00A50533 one cycle later → fetch_done in cycle 3; instr=0x00A50533, instr_pc=0x100, opcode=0110011, rd=10, rs1=10, rs2=10, fetch_error=0.
- pc=0x204, ready held low 3 cycles → mem_addr stays 0x204 and mem_req_valid stays 1 throughout; fetch_start pulses during busy are ignored; the fetch completes normally.
- pc=0x102 → no mem_req_valid; fetch_done in cycle 1 with fetch_error=1, err_cause=01; instr unchanged. The next aligned fetch clears the error.
- TIMEOUT=4, request accepted, no response → fetch_error=1, err_cause=10, instr unchanged. A late response in IDLE does not change instr. Repeat with the response arriving on the final wait cycle → the fetch succeeds.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port of the fetch unit: a valid/ready request channel
// and a valid-only response channel (memory cannot stall a response).
interface instr_fetch_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multi-cycle RV32I core: takes a one-cycle
// fetch_start from the control FSM, reads instruction memory at pc, holds the
// returned word in the instruction register and exposes its decode fields.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for fetch_start; responses arriving here are dropped
// REQ   | mem_req_valid held with a stable address until mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid or the timeout
// DONE  | one-cycle fetch_done pulse (success or error), then IDLE
module instr_fetch_unit #(
    parameter int          TIMEOUT   = 16,            // legal range 2..255
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_start,
    input  logic [31:0]                pc,
    instr_fetch_unit_if.master         mem,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [6:0]                 opcode,
    output logic [2:0]                 func3,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic                       fetch_busy,
    output logic                       fetch_done,
    output logic                       fetch_error,
    output logic [1:0]                 err_cause
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;

    // The wait timer counts down from TIMEOUT-1; hitting zero with no
    // response marks the last allowed WAIT cycle, giving TIMEOUT WAIT
    // cycles in total.
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic [31:0] addr_q,      addr_d;
    logic [7:0]  wait_cnt_q,  wait_cnt_d;
    logic [31:0] instr_q,     instr_d;
    logic [31:0] instr_pc_q,  instr_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        error_q,     error_d;
    logic [1:0]  cause_q,     cause_d;

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wait_cnt_d  = wait_cnt_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        req_valid_d = req_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        cause_d     = cause_q;

        unique case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    error_d = 1'b0;
                    cause_d = CAUSE_NONE;
                    if (pc[1:0] == 2'b00) begin
                        addr_d      = pc;
                        req_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        // Misaligned pc never reaches memory.
                        error_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_REQ: begin
                if (req_valid_q && mem.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    wait_cnt_d  = WAIT_LOAD;
                    state_d     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    // A response on the final wait cycle still wins.
                    instr_d    = mem.mem_rsp_data;
                    instr_pc_d = addr_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else if (wait_cnt_q == 8'd0) begin
                    error_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset also drops mem_req_valid at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            wait_cnt_q  <= 8'd0;
            instr_q     <= NOP_INSTR;
            instr_pc_q  <= 32'd0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cause_q     <= cause_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_addr      = addr_q;

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_busy  = busy_q;
    assign fetch_done  = done_q;
    assign fetch_error = error_q;
    assign err_cause   = cause_q;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign func3  = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a completion scoreboard.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_error;
    logic [1:0]  err_cause;

    instr_fetch_unit_if mem_if ();

    instr_fetch_unit #(
        .TIMEOUT   (4),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .pc          (pc),
        .mem         (mem_if),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .func3       (func3),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .fetch_error (fetch_error),
        .err_cause   (err_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic e, input logic [1:0] c);
        exp_t x;
        x.instr = i;
        x.pc    = p;
        x.err   = e;
        x.cause = c;
        sb_q.push_back(x);
    endtask

    // Called when fetch_done is observed: pop the oldest expectation.
    task automatic sb_check(input string tag);
        exp_t x;
        checks++;
        assert (sb_q.size() != 0)
        else begin
            errors++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            chk({tag, "_instr"}, instr, x.instr);
            chk({tag, "_instr_pc"}, instr_pc, x.pc);
            chk({tag, "_error"}, {31'd0, fetch_error}, {31'd0, x.err});
            chk({tag, "_cause"}, {30'd0, err_cause}, {30'd0, x.cause});
        end
    endtask

    task automatic wait_done(input int max_cycles, output int n);
        n = 0;
        while (!fetch_done && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        rst_n                = 1'b0;
        fetch_start          = 1'b0;
        pc                   = 32'd0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_data  = 32'd0;
        tick();
        tick();

        // Reset values.
        chk("rst_instr", instr, NOP);
        chk("rst_opcode", {25'd0, opcode}, 32'h13);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_req_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        chk("rst_addr", mem_if.mem_addr, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_error", {31'd0, fetch_error}, 32'd0);
        chk("rst_cause", {30'd0, err_cause}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Minimum-latency fetch: add x10,x10,x10 from 0x100.
        pc = 32'h100;
        fetch_start = 1'b1;
        push(32'h00A5_0533, 32'h100, 1'b0, 2'b00);
        tick();
        fetch_start = 1'b0;
        chk("a_req_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
        chk("a_addr", mem_if.mem_addr, 32'h100);
        chk("a_busy", {31'd0, fetch_busy}, 32'd1);
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        chk("a_req_dropped", {31'd0, mem_if.mem_req_valid}, 32'd0);
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = 32'h00A5_0533;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("a_done_cycle3", {31'd0, fetch_done}, 32'd1);
        sb_check("a");
        chk("a_opcode", {25'd0, opcode}, 32'h33);
        chk("a_rd", {27'd0, rd}, 32'd10);
        chk("a_rs1", {27'd0, rs1}, 32'd10);
        chk("a_rs2", {27'd0, rs2}, 32'd10);
        chk("a_func3", {29'd0, func3}, 32'd0);
        tick();
        chk("a_done_pulse", {31'd0, fetch_done}, 32'd0);
        chk("a_busy_end", {31'd0, fetch_busy}, 32'd0);

        // Backpressured request with ignored fetch_start pulses.
        pc = 32'h204;
        fetch_start = 1'b1;
        push(32'h0041_8193, 32'h204, 1'b0, 2'b00);
        tick();
        fetch_start = 1'b0;
        pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            chk("b_hold_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
            chk("b_hold_addr", mem_if.mem_addr, 32'h204);
            fetch_start = (i == 1);
            tick();
        end
        fetch_start = 1'b0;
        chk("b_hold_valid_last", {31'd0, mem_if.mem_req_valid}, 32'd1);
        chk("b_hold_addr_last", mem_if.mem_addr, 32'h204);
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = 32'h0041_8193;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("b_done", {31'd0, fetch_done}, 32'd1);
        sb_check("b");
        chk("b_rd", {27'd0, rd}, 32'd3);
        pc = 32'h400;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        chk("b_start_in_done_ignored", {31'd0, mem_if.mem_req_valid}, 32'd0);
        chk("b_idle_busy", {31'd0, fetch_busy}, 32'd0);

        // Misaligned pc: immediate error, no request, instr unchanged.
        pc = 32'h102;
        fetch_start = 1'b1;
        push(32'h0041_8193, 32'h204, 1'b1, 2'b01);
        tick();
        fetch_start = 1'b0;
        chk("c_done_cycle1", {31'd0, fetch_done}, 32'd1);
        chk("c_no_req", {31'd0, mem_if.mem_req_valid}, 32'd0);
        sb_check("c");
        tick();
        chk("c_error_held", {31'd0, fetch_error}, 32'd1);

        // Next aligned fetch clears the error as soon as it is accepted.
        pc = 32'h008;
        fetch_start = 1'b1;
        push(32'h0000_0073, 32'h008, 1'b0, 2'b00);
        tick();
        fetch_start = 1'b0;
        chk("c_error_cleared", {31'd0, fetch_error}, 32'd0);
        chk("c_cause_cleared", {30'd0, err_cause}, 32'd0);
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = 32'h0000_0073;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("c2_done", {31'd0, fetch_done}, 32'd1);
        sb_check("c2");
        tick();

        // Timeout after four silent WAIT cycles.
        pc = 32'h010;
        fetch_start = 1'b1;
        push(32'h0000_0073, 32'h008, 1'b1, 2'b10);
        tick();
        fetch_start = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        wait_done(10, n);
        chk("d_timeout_latency", n, 32'd4);
        sb_check("d");
        tick();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("d_late_rsp_instr", instr, 32'h0000_0073);
        chk("d_late_rsp_done", {31'd0, fetch_done}, 32'd0);
        tick();

        // Response on the final WAIT cycle beats the timeout.
        pc = 32'h020;
        fetch_start = 1'b1;
        push(32'h00C5_8633, 32'h020, 1'b0, 2'b00);
        tick();
        fetch_start = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("e_still_waiting", {31'd0, fetch_done}, 32'd0);
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = 32'h00C5_8633;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("e_done", {31'd0, fetch_done}, 32'd1);
        sb_check("e");
        chk("e_rd", {27'd0, rd}, 32'd12);
        chk("e_rs1", {27'd0, rs1}, 32'd11);
        tick();

        // Reset during REQ drops mem_req_valid without a clock edge.
        pc = 32'h040;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("f_req_before_rst", {31'd0, mem_if.mem_req_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("f_rst_req_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        chk("f_rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("f_rst_instr", instr, NOP);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during WAIT, then a stale response in IDLE is ignored.
        pc = 32'h044;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        tick();
        mem_if.mem_req_ready = 1'b0;
        chk("g_busy_in_wait", {31'd0, fetch_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("g_rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("g_rst_req_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
        chk("g_rst_addr", mem_if.mem_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_data  = 32'hCAFE_F00D;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("g_stale_rsp_instr", instr, NOP);
        chk("g_stale_rsp_pc", instr_pc, 32'd0);
        chk("g_stale_rsp_done", {31'd0, fetch_done}, 32'd0);
        tick();

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
